// File: rtl/stage_exe.sv
// Execute stage with EXE/MEM pipeline register. Single-cycle ALU/shift/jal results
// are registered directly; mul iterates MUL_BITS multiplier bits per negedge.
`timescale 1ns/1ps
module stage_exe #(
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic [4:0]  ern,
  input  logic [31:0] eqa,
  input  logic [31:0] eqb,
  input  logic [31:0] eimm,
  input  logic [31:0] epc4,
  input  logic        flush,
  output logic        stall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [4:0]  mrn,
  output logic [31:0] malu,
  output logic [31:0] mqb
);

  localparam int N = 32 / MUL_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] mcand_reg, mplier_reg, acc_reg;
  logic [5:0]  count_reg;

  logic [31:0] a, b, alu_res, result, psum;
  logic        is_mul, bubble, commit;
  logic [31:0] pp [MUL_BITS];

  assign a      = eshift ? {27'b0, eimm[10:6]} : eqa;
  assign b      = ealuimm ? eimm : eqb;
  // jal overrides the function code, so a jal never starts the multiplier
  assign is_mul = (ealuc == 4'b1011) && !ejal;

  always_comb begin
    alu_res = 32'd0;
    casez (ealuc)
      4'b?000: alu_res = a + b;
      4'b?100: alu_res = a - b;
      4'b?001: alu_res = a & b;
      4'b?101: alu_res = a | b;
      4'b?010: alu_res = a ^ b;
      4'b?110: alu_res = {b[15:0], 16'b0};
      4'b0011: alu_res = b << a[4:0];
      4'b0111: alu_res = b >> a[4:0];
      4'b1111: alu_res = 32'($signed(b) >>> a[4:0]);
      default: alu_res = 32'd0;
    endcase
  end

  assign result = ejal ? epc4 : alu_res;

  // partial products for the multiplier digit retired this iteration
  generate
    for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    psum = 32'd0;
    for (int i = 0; i < MUL_BITS; i++) psum = psum + pp[i];
  end

  // state register
  always_ff @(negedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (is_mul) state_next = BUSY;
        BUSY:    if (count_reg == 6'(N - 1)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // output logic
  always_comb begin
    stall  = is_mul && (state_reg != DONE) && !flush;
    commit = (state_reg == DONE) && !flush;
    bubble = flush || (state_reg == BUSY) || ((state_reg == IDLE) && is_mul);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= 32'd0;
      mplier_reg <= 32'd0;
      acc_reg    <= 32'd0;
      count_reg  <= 6'd0;
    end else if (flush) begin
      acc_reg   <= 32'd0;
      count_reg <= 6'd0;
    end else if (state_reg == IDLE && is_mul) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= 32'd0;
      count_reg  <= 6'd0;
    end else if (state_reg == BUSY) begin
      acc_reg    <= acc_reg + psum;
      mcand_reg  <= mcand_reg << MUL_BITS;
      mplier_reg <= mplier_reg >> MUL_BITS;
      count_reg  <= count_reg + 6'd1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      mrn    <= 5'd0;
      malu   <= 32'd0;
      mqb    <= 32'd0;
    end else if (bubble) begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      mrn    <= 5'd0;
      malu   <= 32'd0;
      mqb    <= 32'd0;
    end else begin
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
      mrn    <= ern;
      malu   <= commit ? acc_reg : result;
      mqb    <= eqb;
    end
  end

endmodule

// File: tb/tb_stage_exe.sv
// Directed bench for stage_exe: vector table for single-cycle ops plus multiply,
// flush and reset sequences on MUL_BITS=1 and MUL_BITS=4 instances in parallel.
`timescale 1ns/1ps
module tb_stage_exe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal, flush;
  logic [3:0]  ealuc;
  logic [4:0]  ern;
  logic [31:0] eqa, eqb, eimm, epc4;

  logic        stall1, mwreg1, mm2reg1, mwmem1;
  logic [4:0]  mrn1;
  logic [31:0] malu1, mqb1;
  logic        stall4, mwreg4, mm2reg4, mwmem4;
  logic [4:0]  mrn4;
  logic [31:0] malu4, mqb4;
  logic [71:0] o1, o4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_exe #(.MUL_BITS(1)) u1 (
    .clk(clk), .rst(rst), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .ern(ern),
    .eqa(eqa), .eqb(eqb), .eimm(eimm), .epc4(epc4), .flush(flush),
    .stall(stall1), .mwreg(mwreg1), .mm2reg(mm2reg1), .mwmem(mwmem1),
    .mrn(mrn1), .malu(malu1), .mqb(mqb1)
  );

  stage_exe #(.MUL_BITS(4)) u4 (
    .clk(clk), .rst(rst), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .ern(ern),
    .eqa(eqa), .eqb(eqb), .eimm(eimm), .epc4(epc4), .flush(flush),
    .stall(stall4), .mwreg(mwreg4), .mm2reg(mm2reg4), .mwmem(mwmem4),
    .mrn(mrn4), .malu(malu4), .mqb(mqb4)
  );

  assign o1 = {mwreg1, mm2reg1, mwmem1, mrn1, malu1, mqb1};
  assign o4 = {mwreg4, mm2reg4, mwmem4, mrn4, malu4, mqb4};

  typedef struct {
    logic [3:0]  aluc;
    logic        aluimm, shift, jal, wreg, m2reg, wmem;
    logic [4:0]  rn;
    logic [31:0] qa, qb, imm, pc4, exp;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [71:0] ex(input logic w, input logic m, input logic s,
                                     input logic [4:0] rn, input logic [31:0] alu,
                                     input logic [31:0] qb);
    return {w, m, s, rn, alu, qb};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] aluc, input logic aluimm, input logic shift,
                        input logic jal, input logic wreg, input logic m2reg,
                        input logic wmem, input logic [4:0] rn, input logic [31:0] qa,
                        input logic [31:0] qb, input logic [31:0] imm,
                        input logic [31:0] pc4);
    ealuc = aluc; ealuimm = aluimm; eshift = shift; ejal = jal;
    ewreg = wreg; em2reg = m2reg; ewmem = wmem; ern = rn;
    eqa = qa; eqb = qb; eimm = imm; epc4 = pc4;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_mul();
    set_op(4'b1011, 0, 0, 0, 1, 0, 0, 5'd9, 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0);
  endtask

  logic [71:0] mul_ok;
  logic [71:0] zero72;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    mul_ok = ex(1, 0, 0, 5'd9, 32'hFFFFFFEB, 32'hFFFFFFFD);
    zero72 = '0;
    vecs[0]  = '{4'b0000, 1, 0, 0, 1, 0, 0, 5'd7,  32'd5,         32'd0,         32'hFFFFFFFD, 32'd0,     32'd2};
    vecs[1]  = '{4'b0100, 0, 0, 0, 1, 0, 0, 5'd3,  32'd10,        32'd3,         32'd0,        32'd0,     32'd7};
    vecs[2]  = '{4'b1001, 0, 0, 0, 1, 0, 0, 5'd4,  32'hF0F0F0F0,  32'hFF00FF00,  32'd0,        32'd0,     32'hF000F000};
    vecs[3]  = '{4'b0101, 0, 0, 0, 1, 0, 0, 5'd5,  32'h000000F0,  32'h0000000F,  32'd0,        32'd0,     32'h000000FF};
    vecs[4]  = '{4'b1010, 0, 0, 0, 1, 0, 0, 5'd6,  32'hFFFF0000,  32'h0F0F0F0F,  32'd0,        32'd0,     32'hF0F00F0F};
    vecs[5]  = '{4'b1110, 1, 0, 0, 1, 0, 0, 5'd8,  32'd0,         32'h00000055,  32'h00001234, 32'd0,     32'h12340000};
    vecs[6]  = '{4'b0011, 0, 1, 0, 1, 0, 0, 5'd10, 32'hFFFFFFFF,  32'h00000001,  32'h00000100, 32'd0,     32'h00000010};
    vecs[7]  = '{4'b0111, 0, 1, 0, 1, 0, 0, 5'd11, 32'd0,         32'h80000000,  32'h00000100, 32'd0,     32'h08000000};
    vecs[8]  = '{4'b1111, 0, 1, 0, 1, 0, 0, 5'd13, 32'd0,         32'h80000000,  32'h00000100, 32'd0,     32'hF8000000};
    vecs[9]  = '{4'b1011, 0, 0, 1, 1, 0, 0, 5'd31, 32'd7,         32'd3,         32'd0,        32'h104,   32'h00000104};
    vecs[10] = '{4'b0000, 1, 0, 0, 0, 0, 1, 5'd0,  32'h00000100,  32'hDEADBEEF,  32'd8,        32'd0,     32'h00000108};
    vecs[11] = '{4'b1000, 1, 0, 0, 1, 1, 0, 5'd12, 32'h00000200,  32'd0,         32'hFFFFFFFC, 32'd0,     32'h000001FC};
    vecs[12] = '{4'b0011, 0, 0, 0, 1, 0, 0, 5'd14, 32'h00000025,  32'h00000001,  32'd0,        32'd0,     32'h00000020};
    vecs[13] = '{4'b1111, 0, 1, 0, 1, 0, 0, 5'd15, 32'd0,         32'h80000001,  32'd0,        32'd0,     32'h80000001};

    // reset with the clock running
    flush = 0;
    set_op(4'b0000, 0, 0, 0, 1, 1, 1, 5'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    rst = 1;
    step(); step();
    chk("reset_o1", o1, zero72);
    chk("reset_o4", o4, zero72);
    chk("reset_stall1", stall1, 0);
    chk("reset_stall4", stall4, 0);
    rst = 0;

    // single-cycle vector table
    for (int i = 0; i < 14; i++) begin
      set_op(vecs[i].aluc, vecs[i].aluimm, vecs[i].shift, vecs[i].jal, vecs[i].wreg,
             vecs[i].m2reg, vecs[i].wmem, vecs[i].rn, vecs[i].qa, vecs[i].qb,
             vecs[i].imm, vecs[i].pc4);
      #1;
      chk($sformatf("vec%0d_stall1", i), stall1, 0);
      chk($sformatf("vec%0d_stall4", i), stall4, 0);
      step();
      chk($sformatf("vec%0d_o1", i), o1,
          ex(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].rn, vecs[i].exp, vecs[i].qb));
      chk($sformatf("vec%0d_o4", i), o4,
          ex(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].rn, vecs[i].exp, vecs[i].qb));
    end

    // multiply held in EXE: x1 commits on edge 33, x4 commits every 10 edges
    set_mul();
    for (int e = 0; e <= 33; e++) begin
      #1;
      chk($sformatf("mul_e%0d_stall1", e), stall1, (e <= 32));
      chk($sformatf("mul_e%0d_stall4", e), stall4, ((e % 10) <= 8));
      step();
      chk($sformatf("mul_e%0d_o1", e), o1, (e == 33) ? mul_ok : zero72);
      chk($sformatf("mul_e%0d_o4", e), o4, ((e % 10) == 9) ? mul_ok : zero72);
    end

    // flush while x4 is busy and x1 would reload
    flush = 1;
    #1;
    chk("flushA_stall1", stall1, 0);
    chk("flushA_stall4", stall4, 0);
    step();
    chk("flushA_o1", o1, zero72);
    chk("flushA_o4", o4, zero72);
    flush = 0;
    set_op(4'b0000, 0, 0, 0, 1, 0, 0, 5'd1, 32'd1, 32'd1, 32'd0, 32'd0);
    step();
    chk("flushA_add_o1", o1, ex(1, 0, 0, 5'd1, 32'd2, 32'd1));
    chk("flushA_add_o4", o4, ex(1, 0, 0, 5'd1, 32'd2, 32'd1));

    // flush on the load edge: no load, next add completes in one edge
    set_mul();
    flush = 1;
    #1;
    chk("flushL_stall1", stall1, 0);
    step();
    chk("flushL_o1", o1, zero72);
    chk("flushL_o4", o4, zero72);
    flush = 0;
    set_op(4'b0000, 0, 0, 0, 1, 0, 0, 5'd1, 32'd1, 32'd1, 32'd0, 32'd0);
    step();
    chk("flushL_add_o1", o1, ex(1, 0, 0, 5'd1, 32'd2, 32'd1));
    chk("flushL_add_o4", o4, ex(1, 0, 0, 5'd1, 32'd2, 32'd1));

    // flush on BUSY edge 10 of the x1 multiply
    set_mul();
    for (int e = 0; e <= 9; e++) begin
      #1;
      chk($sformatf("fm_e%0d_stall1", e), stall1, 1);
      chk($sformatf("fm_e%0d_stall4", e), stall4, (e <= 8));
      step();
      chk($sformatf("fm_e%0d_o1", e), o1, zero72);
      chk($sformatf("fm_e%0d_o4", e), o4, (e == 9) ? mul_ok : zero72);
    end
    flush = 1;
    #1;
    chk("fm_e10_stall1", stall1, 0);
    chk("fm_e10_stall4", stall4, 0);
    step();
    chk("fm_e10_o1", o1, zero72);
    chk("fm_e10_o4", o4, zero72);
    flush = 0;
    set_op(4'b0000, 0, 0, 0, 1, 0, 0, 5'd2, 32'd40, 32'd2, 32'd0, 32'd0);
    for (int e = 11; e <= 36; e++) begin
      step();
      chk($sformatf("fm_post_e%0d_o1", e), o1, ex(1, 0, 0, 5'd2, 32'd42, 32'd2));
    end

    // reset during BUSY edge 5
    set_mul();
    for (int e = 0; e <= 4; e++) step();
    #2;
    rst = 1;
    #1;
    chk("rstm_stall1_mul", stall1, 1);
    set_op(4'b0000, 0, 0, 0, 1, 0, 0, 5'd2, 32'd3, 32'd4, 32'd0, 32'd0);
    #1;
    chk("rstm_stall1", stall1, 0);
    chk("rstm_stall4", stall4, 0);
    step();
    chk("rstm_hold_o1", o1, zero72);
    rst = 0;
    for (int e = 0; e < 4; e++) begin
      step();
      chk($sformatf("rstm_add%0d_o1", e), o1, ex(1, 0, 0, 5'd2, 32'd7, 32'd4));
      chk($sformatf("rstm_add%0d_o4", e), o4, ex(1, 0, 0, 5'd2, 32'd7, 32'd4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
